// File: rtl/proc_exec_sequencer.sv
// Execution sequencer: walks an address window of the A/B/op memories, issuing one read per
// cycle and writing each ALU result to the result memory one cycle later.
module proc_exec_sequencer #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = ADDR_WIDTH + 1,
    parameter int unsigned CYC_WIDTH  = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [CNT_WIDTH-1:0]  count_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  host_sel_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [CYC_WIDTH-1:0]  cyc_cnt_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

    localparam logic [CNT_WIDTH-1:0] MaxCount = CNT_WIDTH'(1) << ADDR_WIDTH;

    state_e                state_q;
    logic                  start_q;
    logic [CNT_WIDTH-1:0]  rem_q;
    logic                  start_edge;
    logic [CNT_WIDTH-1:0]  cnt_sat;
    logic [CYC_WIDTH-1:0]  cyc_inc;

    assign start_edge = start_i & ~start_q;
    assign cnt_sat    = (count_i > MaxCount) ? MaxCount : count_i;
    assign cyc_inc    = (cyc_cnt_o == '1) ? cyc_cnt_o : cyc_cnt_o + CYC_WIDTH'(1);

    // rd_addr_o doubles as the issue pointer; rem_q counts reads left including the one on the port.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            rem_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            host_sel_o <= 1'b1;
            rd_en_o    <= 1'b0;
            rd_addr_o  <= '0;
            wr_en_o    <= 1'b0;
            wr_addr_o  <= '0;
            cyc_cnt_o  <= '0;
        end else begin
            start_q   <= start_i;
            wr_en_o   <= rd_en_o;
            wr_addr_o <= rd_addr_o;

            if (state_q == StRun || state_q == StDrain) begin
                cyc_cnt_o <= cyc_inc;
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start_edge) begin
                        done_o    <= 1'b0;
                        cyc_cnt_o <= '0;
                        if (cnt_sat == '0) begin
                            state_q <= StDone;
                            done_o  <= 1'b1;
                        end else begin
                            state_q    <= StRun;
                            busy_o     <= 1'b1;
                            host_sel_o <= 1'b0;
                            rd_en_o    <= 1'b1;
                            rd_addr_o  <= base_addr_i;
                            rem_q      <= cnt_sat;
                        end
                    end
                end
                StRun: begin
                    if (rem_q == CNT_WIDTH'(1)) begin
                        rd_en_o <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        rd_addr_o <= rd_addr_o + ADDR_WIDTH'(1);
                        rem_q     <= rem_q - CNT_WIDTH'(1);
                    end
                end
                StDrain: begin
                    state_q    <= StDone;
                    busy_o     <= 1'b0;
                    host_sel_o <= 1'b1;
                    done_o     <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_exec_sequencer.sv
// Bench for proc_exec_sequencer: models the A/B/op memories, registered read and ALU, and
// scoreboards every read and write against the expected address window.
module tb_proc_exec_sequencer;

    localparam int AW    = 10;
    localparam int CW    = 11;
    localparam int YW    = 32;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [CW-1:0] count_i = '0;
    logic          busy_o, done_o, host_sel_o, rd_en_o, wr_en_o;
    logic [AW-1:0] rd_addr_o, wr_addr_o;
    logic [YW-1:0] cyc_cnt_o;

    proc_exec_sequencer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW), .CYC_WIDTH(YW)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .count_i    (count_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .host_sel_o (host_sel_o),
        .rd_en_o    (rd_en_o),
        .rd_addr_o  (rd_addr_o),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o),
        .cyc_cnt_o  (cyc_cnt_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_a [DEPTH];
    logic [7:0] mem_b [DEPTH];
    logic [2:0] mem_op[DEPTH];
    logic [7:0] res_mem[DEPTH];
    logic [7:0] a_q = '0, b_q = '0;
    logic [2:0] op_q = '0;

    int         rd_q[$];
    int         wr_q[$];
    logic [7:0] wd_q[$];
    bit         mon_en = 1'b0;
    int         wr_cnt = 0;

    typedef struct {
        int base;
        int cnt;
        int exp_k;
        int exp_cyc;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
        case (op)
            3'd0: alu = a + b;
            3'd1: alu = a - b;
            3'd2: alu = a & b;
            3'd3: alu = a | b;
            3'd4: alu = a ^ b;
            3'd5: alu = ~a;
            3'd6: alu = a << b[2:0];
            default: alu = b;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Registered memory output feeding the combinational ALU.
    always @(posedge clk) begin
        if (rd_en_o) begin
            a_q  <= mem_a[rd_addr_o];
            b_q  <= mem_b[rd_addr_o];
            op_q <= mem_op[rd_addr_o];
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (rd_en_o) begin
                if (rd_q.size() == 0) chk("rd_unexpected", rd_en_o, 0);
                else chk("rd_addr", rd_addr_o, rd_q.pop_front());
            end
            if (wr_en_o) begin
                wr_cnt++;
                res_mem[wr_addr_o] = alu(a_q, b_q, op_q);
                if (wr_q.size() == 0) chk("wr_unexpected", wr_en_o, 0);
                else begin
                    chk("wr_addr", wr_addr_o, wr_q.pop_front());
                    chk("wr_data", alu(a_q, b_q, op_q), wd_q.pop_front());
                end
            end
        end
    end

    task automatic run_job(input int base, input int cnt, input int exp_k, input int exp_cyc,
                           input bit hold, input int glitch_at);
        int n;
        int k;
        int last;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        for (int i = 0; i < n; i++) begin
            int a;
            a = (base + i) % DEPTH;
            rd_q.push_back(a);
            wr_q.push_back(a);
            wd_q.push_back(alu(mem_a[a], mem_b[a], mem_op[a]));
        end
        wr_cnt = 0;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = base[AW-1:0];
        count_i     = cnt[CW-1:0];
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
        k = 0;
        @(negedge clk);
        chk("busy_after_start", busy_o, n > 0);
        chk("done_after_start", done_o, n == 0);
        while (!done_o && k <= exp_k + 20) begin
            if (glitch_at >= 0 && k == glitch_at) begin
                start_i     = 1'b1;
                base_addr_i = 10'd500;
                count_i     = 11'd5;
            end
            if (glitch_at >= 0 && k == glitch_at + 1) start_i = 1'b0;
            @(negedge clk);
            k++;
        end
        chk("done_latency", k, exp_k);
        chk("busy_at_done", busy_o, 0);
        chk("host_sel_at_done", host_sel_o, 1);
        chk("cyc_cnt", cyc_cnt_o, exp_cyc);
        chk("writes_seen", wr_cnt, n);
        chk("rd_left", rd_q.size(), 0);
        chk("wr_left", wr_q.size(), 0);
        if (n > 0) begin
            last = (base + n - 1) % DEPTH;
            chk("res_mem_last", res_mem[last], alu(mem_a[last], mem_b[last], mem_op[last]));
        end
        rd_q.delete();
        wr_q.delete();
        wd_q.delete();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i]   = 8'd1;
            mem_b[i]   = 8'd5;
            mem_op[i]  = 3'(i % 8);
            res_mem[i] = 8'd0;
        end
        vecs[0] = '{base: 0,    cnt: 1024, exp_k: 1025, exp_cyc: 1025};
        vecs[1] = '{base: 1020, cnt: 8,    exp_k: 9,    exp_cyc: 9};
        vecs[2] = '{base: 5,    cnt: 1,    exp_k: 2,    exp_cyc: 2};
        vecs[3] = '{base: 100,  cnt: 3,    exp_k: 4,    exp_cyc: 4};
        vecs[4] = '{base: 7,    cnt: 0,    exp_k: 0,    exp_cyc: 0};
        vecs[5] = '{base: 1000, cnt: 2000, exp_k: 1025, exp_cyc: 1025};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_host_sel", host_sel_o, 1);
        chk("rst_rd_en", rd_en_o, 0);
        chk("rst_rd_addr", rd_addr_o, 0);
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_wr_addr", wr_addr_o, 0);
        chk("rst_cyc", cyc_cnt_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_job(vecs[v].base, vecs[v].cnt, vecs[v].exp_k, vecs[v].exp_cyc, 1'b0, -1);
        end

        // Held start: no retrigger after completion; a fresh rising edge starts a new job.
        run_job(200, 4, 5, 5, 1'b1, -1);
        repeat (50) @(negedge clk);
        chk("held_done", done_o, 1);
        chk("held_busy", busy_o, 0);
        @(posedge clk);
        #1 start_i = 1'b0;
        run_job(300, 6, 7, 7, 1'b0, -1);

        // Start edge 10 cycles into a 100-element job is dropped.
        run_job(50, 100, 101, 101, 1'b0, 10);

        // Asynchronous reset mid-run.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        start_i     = 1'b1;
        base_addr_i = '0;
        count_i     = 11'd100;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_host_sel", host_sel_o, 1);
        chk("midrst_rd_en", rd_en_o, 0);
        chk("midrst_wr_en", wr_en_o, 0);
        chk("midrst_cyc", cyc_cnt_o, 0);
        @(negedge clk);
        chk("midrst_wr_en_held", wr_en_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_busy", busy_o, 0);
        chk("postrst_done", done_o, 0);
        chk("postrst_rd_en", rd_en_o, 0);
        chk("postrst_wr_en", wr_en_o, 0);
        run_job(0, 100, 101, 101, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
